exu_mdu_seq: RTL and testbench
==============================

Name: exu_mdu_seq

Overview:
- Iterative multiply/divide sequencer beside the EXU ALU. It executes the RV32M operations that the single-cycle ALU mux does not implement.
- Accepts one operation per valid/ready handshake from the EXU.
- Runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Holds the result until the EXU consumes it.
- Owns the signed/unsigned pre/post-processing and the RISC-V special cases.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, width of the passthrough destination tag (rd).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation request
- in_ready  output  1  sequencer can accept (IDLE and not flush)
- in_op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_src1  input  XLEN  rs1 operand (multiplicand/dividend)
- in_src2  input  XLEN  rs2 operand (multiplier/divisor)
- in_tag  input  TAG_W  destination tag, returned unchanged
- flush  input  1  abort any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  EXU consumes result
- out_result  output  XLEN  final result
- out_tag  output  TAG_W  tag of the result
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (async, any state):
  - state=IDLE, counter=0.
  - out_result=0, out_tag=0; internal accumulators 0.
  - out_valid=0, busy=0.
  - Any in-flight operation is discarded with no output.
- Outputs are combinational from state:
  - in_ready = (state==IDLE) && !flush.
  - out_valid = (state==DONE) && !flush.
  - busy = (state!=IDLE).
- IDLE: on in_valid && in_ready, latch op, tag, operands, sign flags; compute absolute values for the signed operands.
  - MULH: both operands signed. MULHSU: src1 signed only. DIV/REM: both signed. All other ops unsigned.
  - Divisor == 0 → go to DONE next edge, no CALC:
    - DIV/DIVU: result = all-ones.
    - REM/REMU: result = src1.
  - Signed overflow (DIV/REM, src1 == 0x8000_0000, src2 == all-ones) → go to DONE next edge:
    - DIV: result 0x8000_0000.
    - REM: result 0.
  - Otherwise → CALC with counter = 0.
- CALC: one iteration per cycle, exactly XLEN cycles (counter 0..XLEN-1).
  - Multiply: 2*XLEN-bit product, shift-add on the multiplier LSB.
  - Divide: restoring step on an XLEN+1-bit partial remainder; quotient bit shifted in from the LSB side.
  - On counter == XLEN-1: apply sign correction, register out_result, go to DONE.
    - Product negated if the operand signs differ.
    - Quotient negated if the operand signs differ.
    - Remainder takes the dividend's sign.
  - Result selection: MUL = product low half; MULH/MULHSU/MULHU = product high half (after correction); DIV/DIVU = quotient; REM/REMU = remainder.
- DONE: out_valid high; out_result and out_tag stable until the handshake.
  - out_ready → IDLE next edge.
  - No new accept in the same cycle as the output handshake.
- Latency:
  - Normal ops: out_valid first high XLEN+1 cycles after the accept edge.
  - Special cases: 1 cycle after the accept edge.
- flush has priority over everything:
  - Any state → IDLE next edge.
  - in_valid is ignored in the flush cycle.
  - out_valid is masked in the flush cycle, so no output handshake occurs.
  - out_result and out_tag keep their old values.
- Operand inputs are sampled only at the accept edge; later changes to them have no effect.

Test Plan:
1. MUL src1=7, src2=6, tag=3, out_ready=1 → out_valid exactly 33 cycles after accept; result 42; tag 3; back to IDLE next cycle.
2. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. Division, all in 33 cycles:
   - DIV −7/2 → 0xFFFFFFFD.
   - REM −7/2 → 0xFFFFFFFF.
   - DIVU 100/7 → 14.
   - REMU 100/7 → 2.
4. Divisor zero and overflow, each with out_valid 1 cycle after accept:
   - DIV 5/0 → 0xFFFFFFFF.
   - REMU 5/0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM of the same operands → 0.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, result and tag stable; in_ready=0 throughout; a single handshake when out_ready rises.
6. Flush and reset:
   - Flush at CALC cycle 15 → IDLE next edge, no output.
   - A new MUL 3×3 accepted afterwards → 9.
   - rst asserted mid-CALC, asynchronously → out_valid and busy fall immediately.

Source files
------------

// File: rtl/exu_mdu_seq_if.sv
// Handshake bundle between the EXU and the multiply/divide sequencer.
// The sequencer uses the slave side; the EXU (or a bench) uses the master side.
interface exu_mdu_seq_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_src1;
    logic [XLEN-1:0]  in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/exu_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over XLEN
// cycles, on magnitudes; signs are stripped at accept and restored on the last
// iteration. Divide-by-zero and signed overflow finish without iterating.
module exu_mdu_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    exu_mdu_seq_if.slave   bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [TAG_W-1:0]   r_tag;
    logic               r_neg_res;   // product/quotient must be negated
    logic               r_neg_rem;   // remainder takes the dividend's sign
    logic [XLEN-1:0]    r_opb;       // multiplicand (mul) or divisor (div), magnitude
    logic [2*XLEN-1:0]  r_prod;      // {partial product, remaining multiplier bits}
    logic [XLEN-1:0]    r_quo;       // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]    r_rem;       // partial remainder
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_out_tag;

    // Handshake qualifiers
    logic w_in_ready;
    logic w_accept;
    logic w_last;

    assign w_in_ready = (r_state == S_IDLE) && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_cnt == CW'(XLEN - 1));

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == S_DONE) && !bus.flush;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.out_result = r_result;
    assign bus.out_tag    = r_out_tag;

    // Operand pre-processing at accept: signedness, magnitudes, special cases
    logic            w_src1_signed;
    logic            w_src2_signed;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_is_div;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;

    assign w_src1_signed = (bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU) ||
                           (bus.in_op == OP_DIV)  || (bus.in_op == OP_REM);
    assign w_src2_signed = (bus.in_op == OP_MULH) ||
                           (bus.in_op == OP_DIV)  || (bus.in_op == OP_REM);
    assign w_neg1 = w_src1_signed && bus.in_src1[XLEN-1];
    assign w_neg2 = w_src2_signed && bus.in_src2[XLEN-1];
    assign w_abs1 = w_neg1 ? (~bus.in_src1 + 1'b1) : bus.in_src1;
    assign w_abs2 = w_neg2 ? (~bus.in_src2 + 1'b1) : bus.in_src2;

    assign w_is_div   = bus.in_op[2];
    assign w_div_zero = w_is_div && (bus.in_src2 == '0);
    // Only the signed divide ops (DIV, REM) have op[0] clear
    assign w_overflow = w_is_div && !bus.in_op[0] &&
                        (bus.in_src1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (bus.in_src2 == '1);
    assign w_special  = w_div_zero || w_overflow;
    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign w_special_result = w_div_zero
                            ? (bus.in_op[1] ? bus.in_src1 : '1)
                            : (bus.in_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // One iteration step of each engine
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_prod_step;
    logic [XLEN:0]     w_rem_shift;
    logic [XLEN:0]     w_rem_diff;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_step;
    logic [XLEN-1:0]   w_quo_step;

    assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                         (r_prod[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_prod_step = {w_mul_sum, r_prod[XLEN-1:1]};

    assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_opb};
    assign w_qbit      = ~w_rem_diff[XLEN];
    assign w_rem_step  = w_qbit ? w_rem_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
    assign w_quo_step  = {r_quo[XLEN-2:0], w_qbit};

    // Sign correction and result selection on the final iteration
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;

    assign w_prod_fix = r_neg_res ? (~w_prod_step + 1'b1) : w_prod_step;
    assign w_quo_fix  = r_neg_res ? (~w_quo_step + 1'b1)  : w_quo_step;
    assign w_rem_fix  = r_neg_rem ? (~w_rem_step + 1'b1)  : w_rem_step;

    // Pick the architectural result for the latched op
    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:                      w_final = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             w_final = w_quo_fix;
            default:                     w_final = w_rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept)      w_state_next = w_special ? S_DONE : S_CALC;
                S_CALC: if (w_last)        w_state_next = S_DONE;
                S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
                default:                   w_state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: latch operands at accept, iterate in CALC, register the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_tag     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opb     <= '0;
            r_prod    <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_result  <= '0;
            r_out_tag <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_op      <= bus.in_op;
            r_tag     <= bus.in_tag;
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            r_opb     <= w_is_div ? w_abs2 : w_abs1;
            r_prod    <= {{XLEN{1'b0}}, w_abs2};
            r_quo     <= w_abs1;
            r_rem     <= '0;
            if (w_special) begin
                r_result  <= w_special_result;
                r_out_tag <= bus.in_tag;
            end
        end else if ((r_state == S_CALC) && !bus.flush) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op[2]) begin
                r_rem <= w_rem_step;
                r_quo <= w_quo_step;
            end else begin
                r_prod <= w_prod_step;
            end
            if (w_last) begin
                r_result  <= w_final;
                r_out_tag <= r_tag;
            end
        end
    end
endmodule

// File: tb/tb_exu_mdu_seq.sv
// Directed bench for exu_mdu_seq: latency, arithmetic, special cases,
// backpressure, flush and asynchronous reset.
module tb_exu_mdu_seq;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    exu_mdu_seq_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    exu_mdu_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Present one op at a negedge, accept on the following posedge, then
    // scramble the operand inputs to prove they are not re-sampled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_tag   = tag;
        #1;
        chk("accept_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_src1  = 32'hDEAD_BEEF;
        bus.in_src2  = 32'h1234_5678;
        bus.in_tag   = 5'h1F;
    endtask

    // Cycles from the accept cycle to the first cycle with out_valid high
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) return;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b, tag);
        wait_valid(lat);
        chk({name, "/latency"}, lat, exp_lat);
        chk({name, "/result"}, bus.out_result, exp);
        chk({name, "/tag"}, bus.out_tag, tag);
        @(negedge clk);
        chk({name, "/idle_after"}, {bus.busy, bus.out_valid}, 2'b00);
    endtask

    initial begin
        int lat;
        int bad;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst/out_valid", bus.out_valid, 1'b0);
        chk("rst/busy", bus.busy, 1'b0);
        chk("rst/out_result", bus.out_result, 32'h0);
        chk("rst/out_tag", bus.out_tag, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst/in_ready", bus.in_ready, 1'b1);

        // Multiply
        run_op("MUL_7x6",      3'b000, 32'd7,        32'd6,        5'd3, 32'd42,       33);
        run_op("MULHU_ff",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 33);
        run_op("MULH_ff",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000000, 33);
        run_op("MULHSU_ff",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF, 33);
        run_op("MULH_neg_pos", 3'b001, 32'hFFFFFFFE, 32'd3,        5'd7, 32'hFFFFFFFF, 33);

        // Divide
        run_op("DIV_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33);
        run_op("REM_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33);
        run_op("DIVU_100_7",   3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       33);
        run_op("REMU_100_7",   3'b111, 32'd100,      32'd7,        5'd11, 32'd2,        33);
        run_op("DIV_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 33);

        // Divide by zero and signed overflow
        run_op("DIV_5_0",      3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
        run_op("REMU_5_0",     3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1);
        run_op("DIV_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        run_op("REM_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1);

        // Backpressure: result held for 10 cycles, then exactly one handshake
        bus.out_ready = 1'b0;
        issue(3'b000, 32'd5, 32'd5, 5'd9);
        wait_valid(lat);
        chk("bp/latency", lat, 33);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(bus.out_valid === 1'b1 && bus.out_result === 32'd25 &&
                  bus.out_tag === 5'd9 && bus.in_ready === 1'b0 && bus.busy === 1'b1))
                bad++;
        end
        chk("bp/stable_cycles_bad", bad, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp/valid_at_handshake", bus.out_valid, 1'b1);
        @(negedge clk);
        chk("bp/after_handshake", {bus.busy, bus.out_valid}, 2'b00);

        // Flush mid-CALC, with a request offered during the flush cycle
        issue(3'b000, 32'h1234, 32'h5678, 5'd7);
        repeat (15) @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b000;
        bus.in_src1  = 32'd2;
        bus.in_src2  = 32'd2;
        bus.in_tag   = 5'd1;
        #1;
        chk("flush/in_ready_masked", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush/idle_next", bus.busy, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        chk("flush/no_output", bad, 0);
        chk("flush/result_kept", bus.out_result, 32'd25);
        chk("flush/tag_kept", bus.out_tag, 32'd9);
        run_op("MUL_3x3_after_flush", 3'b000, 32'd3, 32'd3, 5'd2, 32'd9, 33);

        // Flush in DONE masks out_valid and drops the result
        bus.out_ready = 1'b0;
        issue(3'b101, 32'd5, 32'd0, 5'd4);
        wait_valid(lat);
        chk("flush_done/latency", lat, 1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_done/valid_masked", bus.out_valid, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_done/idle", bus.busy, 1'b0);
        chk("flush_done/result_kept", bus.out_result, 32'hFFFFFFFF);
        chk("flush_done/tag_kept", bus.out_tag, 32'd4);

        // Asynchronous reset mid-CALC, checked before any clock edge
        issue(3'b000, 32'd9, 32'd9, 5'd5);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst/busy", bus.busy, 1'b0);
        chk("arst/out_valid", bus.out_valid, 1'b0);
        chk("arst/out_result", bus.out_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("MUL_4x4_after_rst", 3'b000, 32'd4, 32'd4, 5'd6, 32'd16, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
